stim_delay_meter: RTL and testbench
===================================

# stim_delay_meter

Synthesizable stimulus sequencer and propagation-delay meter for small combinational gates under test. On `start` it applies every input vector of an `N_IN`-input gate, in binary or Gray order, and compares the gate output with a built-in reference function. For each vector it counts the clock cycles until the output settles. It reports the worst latency, the vector that caused it, and a count of vectors that never settled. It sits between the lab gate library (NAND/NOR/NOT cells with modelled delays) and the board-level result display, and replaces hand-written per-gate delay benches.

## Interface
- `N_IN`, default 2: gate input count; vectors `0 .. 2^N_IN-1`.
- `CNT_W`, default 8: width of latency and error counters.
- `MAX_WAIT`, default 255: WAIT cycles before a vector is declared timed out; must be below `2^CNT_W`.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle pulse that begins a run; ignored while `busy`.
- `mode`, in, 1: vector order, 0 = binary increment, 1 = Gray code (one input toggles per step); latched at `start`.
- `func_sel`, in, 2: reference function, 00 NAND, 01 NOR, 10 XOR (all of `stim`), 11 NOT `stim[0]`; latched at `start`.
- `dut_out`, in, 1: output of the gate under test.
- `stim`, out, `N_IN`: drives the gate inputs.
- `busy`, out, 1: high from the cycle after `start` through DONE.
- `done`, out, 1: one-cycle pulse on run completion.
- `max_lat`, out, `CNT_W`: worst settled latency of the run.
- `worst_vec`, out, `N_IN`: `stim` value that produced `max_lat`.
- `err_cnt`, out, `CNT_W`: timed-out vectors, saturating.

## Operation
- Reset value of every output is 0. The FSM enters IDLE and the internal index and latency counter clear.
- States:
  - IDLE to APPLY on `start`. Clears `max_lat`, `worst_vec`, `err_cnt` and the index, and latches `mode` and `func_sel`.
  - APPLY: `stim` <= index (mode 0) or index ^ (index >> 1) (mode 1); latency counter <= 0. Goes to WAIT.
  - WAIT: latency counter increments each cycle.
    - On a settled match with latency > `max_lat` (strictly greater, so the first occurrence wins), updates `max_lat` and `worst_vec` <= `stim`. Goes to NEXT.
    - If the counter reaches `MAX_WAIT` without a match, increments `err_cnt` (saturating at `2^CNT_W-1`), records no latency, and goes to NEXT.
  - NEXT: if the index equals `2^N_IN-1`, goes to DONE. Otherwise increments the index and goes to APPLY.
  - DONE: `done` = 1 for this one cycle, then IDLE. Results hold until the next `start`.
- A vector whose expected output equals the previous output matches on the first WAIT cycle.
- `stim` holds its last value in IDLE and DONE.
- Reset asserted mid-run aborts immediately to the reset values. No partial results are kept.

## Timing
- `stim` changes on the clock edge leaving APPLY.
- Latency L means the match was sampled on the L-th WAIT edge after that change. A zero-delay DUT gives L = 1; a DUT with a d-cycle register pipeline gives L = d+1.
- Cycles per vector: 1 APPLY + L (or `MAX_WAIT`) WAIT + 1 NEXT. DONE adds 1 cycle.
- `busy` rises on the edge after `start` and falls on the edge after DONE. `start` arriving in the DONE cycle is ignored.
- `dut_out` is sampled synchronously. The bench or top level synchronises it if it is truly asynchronous.

## Configuration
- `STIM_DELAY_METER_STABLE_EN` defined: a match counts as settled only when `dut_out` equals the expected value on two consecutive WAIT samples. The recorded latency is the first cycle of that pair. This filters single-cycle glitches.
- Not defined: the first matching WAIT sample counts as settled.

## Structure
- Package `stim_meter_pkg` holds:
  - the state enum (IDLE, APPLY, WAIT, NEXT, DONE);
  - `func_sel` code constants (FUNC_NAND, FUNC_NOR, FUNC_XOR, FUNC_NOT).
- Sub-module `ref_gate_model`: combinational, parameter `N_IN`, inputs `stim` and `func_sel`, output `expected`. It is reused by gate-library benches.

## Test plan
- `N_IN`=2, DUT = NAND with 3-cycle pipeline (reset 0), mode 0, func 00: `done` after 4 vectors; `max_lat`=4, `worst_vec`=00, `err_cnt`=0.
- Same DUT, mode 1, func 00: `stim` sequence 00, 01, 11, 10; `max_lat`=4, `worst_vec`=00.
- DUT stuck at 0, `MAX_WAIT`=16, func 00: `err_cnt`=3, `max_lat`=1 (from vector 11), run length 3×18 + 3 + 1 cycles.
- `N_IN`=3, zero-delay XOR DUT, func 10: `max_lat`=1, `err_cnt`=0, 8 vectors applied.
- Reset pulsed during WAIT of vector 2: all outputs 0 next cycle. A new `start` reruns from vector 0 with correct results. `start` pulsed while `busy` has no effect.
- With `STIM_DELAY_METER_STABLE_EN`, DUT glitches to the expected value for 1 cycle, then settles 5 cycles later: latency recorded is that of the stable pair, not the glitch.

Source files
------------

// File: rtl/stim_meter_pkg.sv
// Shared types for the stimulus sequencer / delay meter and the reference gate model.
package stim_meter_pkg;

    localparam int unsigned FUNC_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [FUNC_W-1:0] FUNC_NAND = 2'b00;
    localparam logic [FUNC_W-1:0] FUNC_NOR  = 2'b01;
    localparam logic [FUNC_W-1:0] FUNC_XOR  = 2'b10;
    localparam logic [FUNC_W-1:0] FUNC_NOT  = 2'b11;

endpackage

// File: rtl/ref_gate_model.sv
// Combinational golden model of the lab gate cells; shared with the gate-library benches.
module ref_gate_model
    import stim_meter_pkg::*;
#(
    parameter int unsigned N_IN = 2
) (
    input  logic [N_IN-1:0]   stim,
    input  logic [FUNC_W-1:0] func_sel,
    output logic              expected
);

    always_comb begin
        expected = 1'b0;
        case (func_sel)
            FUNC_NAND: expected = ~(&stim);
            FUNC_NOR:  expected = ~(|stim);
            FUNC_XOR:  expected = ^stim;
            FUNC_NOT:  expected = ~stim[0];
            default:   expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/stim_delay_meter.sv
// Walks every input vector of a small gate and measures cycles until its output settles.
// Define STIM_DELAY_METER_STABLE_EN to require two consecutive matching samples (glitch filter).
module stim_delay_meter
    import stim_meter_pkg::*;
#(
    parameter int unsigned N_IN     = 2,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [FUNC_W-1:0] func_sel,
    input  logic              dut_out,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  max_lat,
    output logic [N_IN-1:0]   worst_vec,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [N_IN-1:0]  LAST_IDX = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]  IDX_ONE  = N_IN'(1);
    localparam logic [CNT_W-1:0] LAT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e              state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]    lat_q, lat_d;
    logic                mode_q, mode_d;
    logic [FUNC_W-1:0]   func_q, func_d;
    logic [N_IN-1:0]     stim_q, stim_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    max_lat_q, max_lat_d;
    logic [N_IN-1:0]     worst_vec_q, worst_vec_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
`ifdef STIM_DELAY_METER_STABLE_EN
    logic                pair_q, pair_d;
`endif

    logic                expected;
    logic                match;
    logic                settled;
    logic [CNT_W-1:0]    lat_inc;
    logic [CNT_W-1:0]    settle_lat;

    ref_gate_model #(.N_IN(N_IN)) u_ref (
        .stim     (stim_q),
        .func_sel (func_q),
        .expected (expected)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        mode_d      = mode_q;
        func_d      = func_q;
        stim_d      = stim_q;
        max_lat_d   = max_lat_q;
        worst_vec_d = worst_vec_q;
        err_cnt_d   = err_cnt_q;
        lat_inc     = lat_q + LAT_ONE;
        match       = (dut_out == expected);
`ifdef STIM_DELAY_METER_STABLE_EN
        pair_d      = pair_q;
        // Latency of a stable pair is that of its first sample (previous WAIT cycle).
        settled     = match && pair_q;
        settle_lat  = lat_q;
`else
        settled     = match;
        settle_lat  = lat_inc;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = APPLY;
                    idx_d       = '0;
                    max_lat_d   = '0;
                    worst_vec_d = '0;
                    err_cnt_d   = '0;
                    mode_d      = mode;
                    func_d      = func_sel;
                end
            end
            APPLY: begin
                stim_d  = mode_q ? (idx_q ^ (idx_q >> 1)) : idx_q;
                lat_d   = '0;
`ifdef STIM_DELAY_METER_STABLE_EN
                pair_d  = 1'b0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_inc;
`ifdef STIM_DELAY_METER_STABLE_EN
                pair_d = match;
`endif
                if (settled) begin
                    // Strictly greater keeps the first vector that hit the worst case.
                    if (settle_lat > max_lat_q) begin
                        max_lat_d   = settle_lat;
                        worst_vec_d = stim_q;
                    end
                    state_d = NEXT;
                end else if (lat_inc == WAIT_LIM) begin
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + LAT_ONE;
                    end
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            lat_q       <= '0;
            mode_q      <= 1'b0;
            func_q      <= '0;
            stim_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            max_lat_q   <= '0;
            worst_vec_q <= '0;
            err_cnt_q   <= '0;
`ifdef STIM_DELAY_METER_STABLE_EN
            pair_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            mode_q      <= mode_d;
            func_q      <= func_d;
            stim_q      <= stim_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            max_lat_q   <= max_lat_d;
            worst_vec_q <= worst_vec_d;
            err_cnt_q   <= err_cnt_d;
`ifdef STIM_DELAY_METER_STABLE_EN
            pair_q      <= pair_d;
`endif
        end
    end

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign max_lat   = max_lat_q;
    assign worst_vec = worst_vec_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_stim_delay_meter.sv
// Scoreboard bench for stim_delay_meter: four meters, each driving its own modelled gate.
module tb_stim_delay_meter;
    import stim_meter_pkg::*;

`ifdef STIM_DELAY_METER_STABLE_EN
    localparam int unsigned STB = 1;
`else
    localparam int unsigned STB = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        string       tag;
        int unsigned lat;
        int unsigned vec;
        int unsigned err;
        int unsigned cyc;
    } run_t;

    run_t sb_a[$];
    run_t sb_b[$];
    run_t sb_c[$];
    run_t sb_d[$];
    logic [1:0] stq[$];
    logic       gray_on = 1'b0;

    // a: NAND, 3-stage pipeline held clear until the run is underway
    logic a_start, a_mode, a_dout, a_busy, a_done;
    logic [1:0] a_func, a_stim, a_worst;
    logic [7:0] a_max, a_err;
    // b: output stuck at 0, short timeout
    logic b_start, b_mode, b_dout, b_busy, b_done;
    logic [1:0] b_func, b_stim, b_worst;
    logic [7:0] b_max, b_err;
    // c: 3-input zero-delay XOR
    logic c_start, c_mode, c_dout, c_busy, c_done;
    logic [1:0] c_func;
    logic [2:0] c_stim, c_worst;
    logic [7:0] c_max, c_err;
    // d: NOT stim[0] with a one-cycle glitch before settling
    logic d_start, d_mode, d_dout, d_busy, d_done;
    logic [1:0] d_func, d_stim, d_worst;
    logic [7:0] d_max, d_err;

    stim_delay_meter #(.N_IN(2), .CNT_W(8), .MAX_WAIT(255)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .func_sel(a_func),
        .dut_out(a_dout), .stim(a_stim), .busy(a_busy), .done(a_done),
        .max_lat(a_max), .worst_vec(a_worst), .err_cnt(a_err));
    stim_delay_meter #(.N_IN(2), .CNT_W(8), .MAX_WAIT(16)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .func_sel(b_func),
        .dut_out(b_dout), .stim(b_stim), .busy(b_busy), .done(b_done),
        .max_lat(b_max), .worst_vec(b_worst), .err_cnt(b_err));
    stim_delay_meter #(.N_IN(3), .CNT_W(8), .MAX_WAIT(255)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .mode(c_mode), .func_sel(c_func),
        .dut_out(c_dout), .stim(c_stim), .busy(c_busy), .done(c_done),
        .max_lat(c_max), .worst_vec(c_worst), .err_cnt(c_err));
    stim_delay_meter #(.N_IN(2), .CNT_W(8), .MAX_WAIT(255)) u_d (
        .clk(clk), .rst_n(rst_n), .start(d_start), .mode(d_mode), .func_sel(d_func),
        .dut_out(d_dout), .stim(d_stim), .busy(d_busy), .done(d_done),
        .max_lat(d_max), .worst_vec(d_worst), .err_cnt(d_err));

    // Gate models
    logic       a_busy1;
    logic [2:0] a_pipe;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_busy1 <= 1'b0;
            a_pipe  <= 3'b000;
        end else begin
            a_busy1 <= a_busy;
            a_pipe  <= a_busy1 ? {a_pipe[1:0], ~(&a_stim)} : 3'b000;
        end
    end
    assign a_dout = a_pipe[2];
    assign b_dout = 1'b0;
    assign c_dout = ^c_stim;

    logic       d_busy1, d_busy2, d_new, d_exp;
    logic [1:0] d_prev;
    logic [3:0] d_age;
    assign d_new  = (d_stim != d_prev) || (d_busy1 && !d_busy2);
    assign d_exp  = ~d_stim[0];
    assign d_dout = d_new ? ~d_exp : (d_age == 4'd1) ? d_exp : (d_age <= 4'd5) ? ~d_exp : d_exp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_busy1 <= 1'b0;
            d_busy2 <= 1'b0;
            d_prev  <= 2'b00;
            d_age   <= 4'd0;
        end else begin
            d_busy1 <= d_busy;
            d_busy2 <= d_busy1;
            d_prev  <= d_stim;
            d_age   <= d_new ? 4'd1 : (d_age == 4'd15) ? 4'd15 : d_age + 4'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int w);
        case (w)
            0:       return sb_a.size();
            1:       return sb_b.size();
            2:       return sb_c.size();
            default: return sb_d.size();
        endcase
    endfunction

    task automatic push_run(input int w, input string tag, input int unsigned lat,
                            input int unsigned vec, input int unsigned err, input int unsigned cyc);
        run_t e;
        e.tag = tag; e.lat = lat; e.vec = vec; e.err = err; e.cyc = cyc;
        case (w)
            0:       sb_a.push_back(e);
            1:       sb_b.push_back(e);
            2:       sb_c.push_back(e);
            default: sb_d.push_back(e);
        endcase
    endtask

    task automatic score(input int w, input logic [31:0] lat, input logic [31:0] vec,
                         input logic [31:0] err, input int unsigned cyc);
        run_t e;
        int   n = qsize(w);
        check_eq($sformatf("sb%0d_pending", w), 32'(n > 0), 32'd1);
        if (n > 0) begin
            case (w)
                0:       e = sb_a.pop_front();
                1:       e = sb_b.pop_front();
                2:       e = sb_c.pop_front();
                default: e = sb_d.pop_front();
            endcase
            check_eq({e.tag, "_max_lat"}, lat, e.lat);
            check_eq({e.tag, "_worst_vec"}, vec, e.vec);
            check_eq({e.tag, "_err_cnt"}, err, e.err);
            check_eq({e.tag, "_cycles"}, cyc, e.cyc);
        end
    endtask

    // Result monitors: busy-cycle count includes the DONE cycle
    int unsigned a_cyc, b_cyc, c_cyc, d_cyc;
    always @(negedge clk) begin
        if (!rst_n) a_cyc <= 0;
        else if (a_done) begin score(0, 32'(a_max), 32'(a_worst), 32'(a_err), a_cyc + 1); a_cyc <= 0; end
        else if (a_busy) a_cyc <= a_cyc + 1;
    end
    always @(negedge clk) begin
        if (!rst_n) b_cyc <= 0;
        else if (b_done) begin score(1, 32'(b_max), 32'(b_worst), 32'(b_err), b_cyc + 1); b_cyc <= 0; end
        else if (b_busy) b_cyc <= b_cyc + 1;
    end
    always @(negedge clk) begin
        if (!rst_n) c_cyc <= 0;
        else if (c_done) begin score(2, 32'(c_max), 32'(c_worst), 32'(c_err), c_cyc + 1); c_cyc <= 0; end
        else if (c_busy) c_cyc <= c_cyc + 1;
    end
    always @(negedge clk) begin
        if (!rst_n) d_cyc <= 0;
        else if (d_done) begin score(3, 32'(d_max), 32'(d_worst), 32'(d_err), d_cyc + 1); d_cyc <= 0; end
        else if (d_busy) d_cyc <= d_cyc + 1;
    end

    // Gray-order stim sequence monitor for u_a
    logic [1:0] a_stim_prev = 2'b00;
    always @(negedge clk) begin
        logic [1:0] want;
        a_stim_prev <= a_stim;
        if (gray_on && a_stim != a_stim_prev) begin
            if (stq.size() > 0) begin
                want = stq.pop_front();
                check_eq("a_gray_stim", 32'(a_stim), 32'(want));
            end else begin
                check_eq("a_gray_extra_step", 32'(stq.size()), 32'd1);
            end
        end
    end

    task automatic kick(input int w, input logic m, input logic [1:0] f);
        @(negedge clk);
        case (w)
            0:       begin a_mode = m; a_func = f; a_start = 1'b1; end
            1:       begin b_mode = m; b_func = f; b_start = 1'b1; end
            2:       begin c_mode = m; c_func = f; c_start = 1'b1; end
            default: begin d_mode = m; d_func = f; d_start = 1'b1; end
        endcase
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; d_start = 1'b0;
    endtask

    task automatic drain(input int w, input int budget);
        int n = 0;
        while (qsize(w) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("drain%0d_timeout", w), 32'(qsize(w)), 32'd0);
    endtask

    initial begin
        logic       seen;
        logic [1:0] prev;
        a_start = 0; a_mode = 0; a_func = 0;
        b_start = 0; b_mode = 0; b_func = 0;
        c_start = 0; c_mode = 0; c_func = 0;
        d_start = 0; d_mode = 0; d_func = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_stim", 32'(a_stim), 0);
        check_eq("rst_busy", 32'(a_busy), 0);
        check_eq("rst_done", 32'(a_done), 0);
        check_eq("rst_max_lat", 32'(a_max), 0);
        check_eq("rst_worst_vec", 32'(a_worst), 0);
        check_eq("rst_err_cnt", 32'(a_err), 0);
        check_eq("rst_stim_b", 32'(b_stim), 0);
        check_eq("rst_stim_c", 32'(c_stim), 0);
        check_eq("rst_stim_d", 32'(d_stim), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Binary NAND run, then a start landing in the DONE cycle
        push_run(0, "a_bin", 4, 0, 0, 19 + 4 * STB);
        kick(0, 1'b0, FUNC_NAND);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = a_done;
        end
        check_eq("a_bin_done_seen", 32'(seen), 1);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check_eq("start_in_done_busy0", 32'(a_busy), 0);
        @(negedge clk);
        check_eq("start_in_done_busy1", 32'(a_busy), 0);
        drain(0, 10);

        // Gray-order NAND run
        repeat (2) @(negedge clk);
        stq.push_back(2'b00); stq.push_back(2'b01); stq.push_back(2'b11); stq.push_back(2'b10);
        gray_on = 1'b1;
        push_run(0, "a_gray", 4, 0, 0, 22 + 4 * STB);
        kick(0, 1'b1, FUNC_NAND);
        drain(0, 200);
        gray_on = 1'b0;
        check_eq("a_gray_steps_left", 32'(stq.size()), 0);

        // Stuck-at-0 against NAND: three timeouts, vector 11 matches immediately
        push_run(1, "b_stuck", 1, 3, 3, 58 + STB);
        kick(1, 1'b0, FUNC_NAND);
        drain(1, 300);

        // 3-input XOR, zero delay, both orders
        push_run(2, "c_xor_bin", 1, 0, 0, 25 + 8 * STB);
        kick(2, 1'b0, FUNC_XOR);
        drain(2, 200);
        push_run(2, "c_xor_gray", 1, 0, 0, 25 + 8 * STB);
        kick(2, 1'b1, FUNC_XOR);
        drain(2, 200);

        // Abort with reset during WAIT of vector 2, then rerun with a stray start
        repeat (2) @(negedge clk);
        kick(0, 1'b0, FUNC_NAND);
        seen = 1'b0;
        prev = a_stim;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (a_stim == 2'b10) && (prev != 2'b10) && a_busy;
            prev = a_stim;
        end
        check_eq("abort_reached_vec2", 32'(seen), 1);
        check_eq("abort_pre_max_lat", 32'(a_max), 4);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_stim", 32'(a_stim), 0);
        check_eq("abort_busy", 32'(a_busy), 0);
        check_eq("abort_done", 32'(a_done), 0);
        check_eq("abort_max_lat", 32'(a_max), 0);
        check_eq("abort_worst_vec", 32'(a_worst), 0);
        check_eq("abort_err_cnt", 32'(a_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push_run(0, "a_rerun", 4, 0, 0, 19 + 4 * STB);
        kick(0, 1'b0, FUNC_NAND);
        repeat (3) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        drain(0, 200);

        // Glitching gate: one early matching sample, stable from the 7th WAIT cycle
        if (STB != 0) push_run(3, "d_glitch", 7, 0, 0, 41);
        else          push_run(3, "d_glitch", 2, 0, 0, 17);
        kick(3, 1'b0, FUNC_NOT);
        drain(3, 300);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
